// File: rtl/credit_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module      : credit_sender_pkg
// Description : Shared constants and helpers for the credit-based link sender.
//               credit_w() gives the width needed to hold a credit count in
//               the range 0..depth inclusive.
// Revision    : 1.0 - initial release
// ============================================================================
package credit_sender_pkg;

    // Width of the credit-return strobe carried through the return pipe.
    localparam int c_ret_w = 1;

    // Bits needed to represent every value from 0 up to and including depth.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dti.sv
`default_nettype none
// ============================================================================
// Module      : dti
// Description : Valid/ready data-transfer interface. A word moves on every
//               cycle where valid and ready are both high.
//   valid : producer has a word on data
//   ready : consumer can take a word this cycle
//   data  : payload, W bits
// Revision    : 1.0 - initial release
// ============================================================================
interface dti #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/credit_sender_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_pipe
// Description : Generic delay line of STAGES register stages. The whole
//               vector (including any valid bit packed into it) is cleared
//               by synchronous reset. STAGES=0 degenerates to a wire.
//   clk : clock
//   rst : synchronous active-high reset
//   d   : input vector, W bits
//   q   : d delayed by STAGES cycles
// Revision    : 1.0 - initial release
// ============================================================================
module shift_pipe #(
    parameter int W      = 1,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_pass
            // Clock and reset are intentionally unused in the zero-stage case.
            logic w_unused;
            assign w_unused = ^{clk, rst};
            assign q        = d;
        end else begin : g_pipe
            logic [W-1:0] r_stage [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign q = r_stage[STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/credit_sender.sv
`default_nettype none
// ============================================================================
// Module      : credit_sender
// Description : Transmit end of a credit-based link. Accepts words from a
//               valid/ready stream and forwards them over a ready-less
//               valid/data link to a DEPTH-entry FIFO receiver. One credit is
//               held per free receiver slot; upstream is stalled when no
//               credits remain. The receiver returns one credit per drained
//               entry on credit_ret.
//   clk        : clock
//   rst        : synchronous active-high reset
//   din        : upstream stream (consumer side), W_DATA-bit payload
//   link_valid : one-cycle pulse per transferred word
//   link_data  : payload, meaningful while link_valid=1
//   credit_ret : one credit returned per cycle high
//   credits    : current credit count (0..DEPTH)
//   ovf_err    : sticky, set when a credit returns while count==DEPTH
// Parameters:
//   DEPTH       : receiver FIFO depth, initial and maximum credit count
//   LINK_STAGES : register stages on the link after the send register
//   RET_STAGES  : register stages on credit_ret before it is counted
//   W_DATA      : payload width, must equal the width of din.data
// Revision    : 1.0 - initial release
// ============================================================================
module credit_sender
    import credit_sender_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int LINK_STAGES = 1,
    parameter int RET_STAGES  = 0,
    parameter int W_DATA      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    dti.consumer                       din,
    output logic                       link_valid,
    output logic [W_DATA-1:0]          link_data,
    input  logic                       credit_ret,
    output logic [credit_w(DEPTH)-1:0] credits,
    output logic                       ovf_err
);

    localparam int                c_cw    = credit_w(DEPTH);
    localparam logic [c_cw-1:0]   c_depth = c_cw'(DEPTH);
    localparam logic [c_cw-1:0]   c_one   = c_cw'(1);

    generate
        if (DEPTH < 1) begin : g_depth_check
            $error("credit_sender: DEPTH must be >= 1 (got %0d)", DEPTH);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_cw-1:0]   r_credits;
    logic              r_ready;
    logic              r_ovf_err;
    logic              r_send_valid;
    logic [W_DATA-1:0] r_send_data;

    logic              w_send;
    logic              w_ret;
    logic [c_cw-1:0]   w_credits_nxt;
    logic              w_ovf_set;

    // ready comes straight from a flop so upstream sees no combinational
    // path from credit_ret or din.valid.
    assign din.ready = r_ready;
    assign w_send    = din.valid & r_ready;

    // ------------------------------------------------------------------
    // Credit return path
    // ------------------------------------------------------------------
    shift_pipe #(
        .W      (c_ret_w),
        .STAGES (RET_STAGES)
    ) u_ret_pipe (
        .clk (clk),
        .rst (rst),
        .d   (credit_ret),
        .q   (w_ret)
    );

    // ------------------------------------------------------------------
    // Credit counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_credits_nxt = r_credits;
        w_ovf_set     = 1'b0;
        if (w_send && !w_ret) begin
            // Cannot underflow: a send needs r_ready, i.e. r_credits != 0.
            w_credits_nxt = r_credits - c_one;
        end else if (!w_send && w_ret) begin
            if (r_credits == c_depth) begin
                // Receiver returned more than it was given: saturate, flag.
                w_ovf_set = 1'b1;
            end else begin
                w_credits_nxt = r_credits + c_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= c_depth;
            r_ready   <= 1'b1;
            r_ovf_err <= 1'b0;
        end else begin
            r_credits <= w_credits_nxt;
            // Registered copy of (credits != 0) for the next cycle.
            r_ready   <= (w_credits_nxt != '0);
            if (w_ovf_set) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Send register: valid pulses for one cycle per accepted word; data
    // holds its last value between sends.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_send_valid <= 1'b0;
            r_send_data  <= '0;
        end else begin
            r_send_valid <= w_send;
            if (w_send) begin
                r_send_data <= din.data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Link pipeline: valid and data travel together through each stage.
    // ------------------------------------------------------------------
    shift_pipe #(
        .W      (W_DATA + 1),
        .STAGES (LINK_STAGES)
    ) u_link_pipe (
        .clk (clk),
        .rst (rst),
        .d   ({r_send_valid, r_send_data}),
        .q   ({link_valid, link_data})
    );

    assign credits = r_credits;
    assign ovf_err = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_credit_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_sender
// Description : Self-checking bench for credit_sender. Instance A uses
//               DEPTH=2, LINK_STAGES=1, RET_STAGES=0 and is checked every
//               cycle against a schedule-based model plus directed literal
//               expectations. Instance B uses LINK_STAGES=0, RET_STAGES=2
//               and is checked with directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_sender;
    import credit_sender_pkg::*;

    localparam int DEPTH = 2;
    localparam int A_LS  = 1;
    localparam int A_RS  = 0;
    localparam int B_LS  = 0;
    localparam int B_RS  = 2;
    localparam int CW    = credit_w(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A ----------------
    dti #(.W(8)) a_if ();
    logic          a_valid = 1'b0;
    logic [7:0]    a_data  = '0;
    logic          a_ret   = 1'b0;
    logic          a_link_valid;
    logic [7:0]    a_link_data;
    logic [CW-1:0] a_credits;
    logic          a_ovf;
    logic          a_ready;
    assign a_if.valid = a_valid;
    assign a_if.data  = a_data;
    assign a_ready    = a_if.ready;

    credit_sender #(
        .DEPTH(DEPTH), .LINK_STAGES(A_LS), .RET_STAGES(A_RS), .W_DATA(8)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .din        (a_if),
        .link_valid (a_link_valid),
        .link_data  (a_link_data),
        .credit_ret (a_ret),
        .credits    (a_credits),
        .ovf_err    (a_ovf)
    );

    // ---------------- instance B ----------------
    dti #(.W(8)) b_if ();
    logic          b_valid = 1'b0;
    logic [7:0]    b_data  = '0;
    logic          b_ret   = 1'b0;
    logic          b_link_valid;
    logic [7:0]    b_link_data;
    logic [CW-1:0] b_credits;
    logic          b_ovf;
    assign b_if.valid = b_valid;
    assign b_if.data  = b_data;

    credit_sender #(
        .DEPTH(DEPTH), .LINK_STAGES(B_LS), .RET_STAGES(B_RS), .W_DATA(8)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .din        (b_if),
        .link_valid (b_link_valid),
        .link_data  (b_link_data),
        .credit_ret (b_ret),
        .credits    (b_credits),
        .ovf_err    (b_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model of instance A ----------------
    // Words are scheduled by the cycle in which they must appear on the
    // link; returns by the cycle in which they take effect.
    int         mcyc   = 0;
    bit         m_live = 1'b0;
    int         m_cred = DEPTH;
    bit         m_ovf  = 1'b0;
    logic [7:0] link_sched [int];
    bit         ret_sched  [int];

    always @(posedge clk) begin : model
        bit send;
        bit r;
        if (rst) begin
            m_live = 1'b1;
            m_cred = DEPTH;
            m_ovf  = 1'b0;
            link_sched.delete();
            ret_sched.delete();
        end else if (m_live) begin
            send = a_valid && (m_cred > 0);
            if (a_ret) ret_sched[mcyc + A_RS] = 1'b1;
            r = ret_sched.exists(mcyc);
            if (send) link_sched[mcyc + 1 + A_LS] = a_data;
            if (send && !r) begin
                m_cred--;
            end else if (!send && r) begin
                if (m_cred == DEPTH) m_ovf = 1'b1;
                else                 m_cred++;
            end
        end
        mcyc++;
        #1;
        if (m_live) begin
            chk("model_credits", 32'(a_credits), m_cred);
            chk("model_ready", 32'(a_ready), (m_cred != 0));
            chk("model_ovf", 32'(a_ovf), 32'(m_ovf));
            chk("model_link_valid", 32'(a_link_valid), 32'(link_sched.exists(mcyc)));
            if (link_sched.exists(mcyc))
                chk("model_link_data", 32'(a_link_data), 32'(link_sched[mcyc]));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] a_q[$];
    int         cyc;
    int         pulses;
    int         stale;

    task automatic load();
        if (a_q.size() > 0) begin
            a_valid = 1'b1;
            a_data  = a_q[0];
        end else begin
            a_valid = 1'b0;
            a_data  = '0;
        end
    endtask

    // Advance to the next negedge, retiring the word that handshook.
    task automatic step();
        bit hs;
        hs = a_valid && a_ready && !rst;
        @(negedge clk);
        cyc++;
        if (hs) void'(a_q.pop_front());
        load();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_credits", 32'(a_credits), 2);
        chk("reset_link_valid", 32'(a_link_valid), 0);
        chk("reset_link_data", 32'(a_link_data), 0);
        chk("reset_ovf", 32'(a_ovf), 0);
        chk("reset_ready", 32'(a_ready), 1);
        chk("b_reset_credits", 32'(b_credits), 2);

        rst = 1'b0;
        a_q = '{8'hA1, 8'hA2, 8'hA3};
        load();
        b_valid = 1'b1;
        b_data  = 8'h5C;
        cyc     = 0;
        pulses  = 0;
        while (cyc < 40) begin
            case (cyc)
                0: begin
                    chk("c0_credits", 32'(a_credits), 2);
                    chk("c0_ready", 32'(a_ready), 1);
                    chk("b_c0_link_valid", 32'(b_link_valid), 0);
                end
                1: begin
                    chk("c1_credits", 32'(a_credits), 1);
                    chk("b_c1_link_valid", 32'(b_link_valid), 1);
                    chk("b_c1_link_data", 32'(b_link_data), 32'h5C);
                    chk("b_c1_credits", 32'(b_credits), 1);
                    b_valid = 1'b0;
                end
                2: begin
                    chk("c2_link_valid", 32'(a_link_valid), 1);
                    chk("c2_link_data", 32'(a_link_data), 32'hA1);
                    chk("c2_credits", 32'(a_credits), 0);
                    chk("c2_ready", 32'(a_ready), 0);
                    chk("b_c2_link_valid", 32'(b_link_valid), 0);
                end
                3: begin
                    chk("c3_link_data", 32'(a_link_data), 32'hA2);
                    chk("b_c3_credits", 32'(b_credits), 1);
                    b_ret = 1'b1;
                end
                4: begin
                    chk("c4_link_valid", 32'(a_link_valid), 0);
                    b_ret = 1'b0;
                end
                5: begin
                    chk("c5_ready", 32'(a_ready), 0);
                    chk("b_c5_credits", 32'(b_credits), 1);
                end
                6: begin
                    chk("b_c6_credits", 32'(b_credits), 2);
                    a_ret = 1'b1;
                end
                7: begin
                    chk("c7_credits", 32'(a_credits), 1);
                    chk("c7_ready", 32'(a_ready), 1);
                    a_ret = 1'b0;
                end
                8: chk("c8_credits", 32'(a_credits), 0);
                9: begin
                    chk("c9_link_valid", 32'(a_link_valid), 1);
                    chk("c9_link_data", 32'(a_link_data), 32'hA3);
                end
                10: a_ret = 1'b1;
                11: begin
                    chk("c11_credits", 32'(a_credits), 1);
                    for (int i = 0; i < 20; i++) a_q.push_back(8'hC0 + 8'(i));
                    load();
                end
                31: a_ret = 1'b0;
                33: begin
                    chk("steady_pulses", pulses, 20);
                    chk("c33_credits", 32'(a_credits), 1);
                end
                default: ;
            endcase
            if (cyc >= 13 && cyc <= 32 && a_link_valid) pulses++;
            step();
        end

        // Overflow: return a credit while already full.
        rst = 1'b1;
        a_q.delete();
        load();
        @(negedge clk);
        chk("rst2_credits", 32'(a_credits), 2);
        rst   = 1'b0;
        cyc   = 0;
        a_ret = 1'b1;
        step();
        a_ret = 1'b0;
        chk("ovf_set", 32'(a_ovf), 1);
        chk("ovf_credits", 32'(a_credits), 2);
        repeat (5) step();
        chk("ovf_sticky", 32'(a_ovf), 1);

        // Reset with two words in flight and no credits left.
        a_q = '{8'hD1, 8'hD2};
        load();
        step();
        step();
        chk("inflight_credits", 32'(a_credits), 0);
        chk("inflight_link_data", 32'(a_link_data), 32'hD1);
        rst = 1'b1;
        step();
        chk("midrst_link_valid", 32'(a_link_valid), 0);
        chk("midrst_credits", 32'(a_credits), 2);
        chk("midrst_ovf", 32'(a_ovf), 0);
        chk("midrst_ready", 32'(a_ready), 1);
        rst   = 1'b0;
        stale = 0;
        repeat (6) begin
            step();
            if (a_link_valid) stale++;
        end
        chk("no_stale_words", stale, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
